// File: rtl/dtfag_mul_demux.sv
// dtfag_mul_demux: return-path demultiplexer for the DTFAG radix-16 twiddle
// datapath. Realigns the 16 multiplier products with the bypass operands and
// route code issued MUL_LAT cycles earlier. It drives one registered radix-16
// word per cycle and counts output groups within a frame.
// Optional feature macro: DTFAG_DEMUX_IFFT_REORDER_EN (route code 2 applies
// the (16-k) mod 16 lane reorder; when it is undefined, code 2 is a straight
// product).
`ifndef D_width
`define D_width 16
`endif

module dtfag_mul_demux #(
  parameter int MUL_LAT   = 3,
  parameter int GROUP_NUM = 4096,
  parameter int CNT_W     = 12
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic [1:0]          Mul_sel,
  input  logic [`D_width-1:0] R16_in0,
  input  logic [`D_width-1:0] R16_in1,
  input  logic [`D_width-1:0] R16_in2,
  input  logic [`D_width-1:0] R16_in3,
  input  logic [`D_width-1:0] R16_in4,
  input  logic [`D_width-1:0] R16_in5,
  input  logic [`D_width-1:0] R16_in6,
  input  logic [`D_width-1:0] R16_in7,
  input  logic [`D_width-1:0] R16_in8,
  input  logic [`D_width-1:0] R16_in9,
  input  logic [`D_width-1:0] R16_in10,
  input  logic [`D_width-1:0] R16_in11,
  input  logic [`D_width-1:0] R16_in12,
  input  logic [`D_width-1:0] R16_in13,
  input  logic [`D_width-1:0] R16_in14,
  input  logic [`D_width-1:0] R16_in15,
  input  logic [`D_width-1:0] MulP0_in,
  input  logic [`D_width-1:0] MulP1_in,
  input  logic [`D_width-1:0] MulP2_in,
  input  logic [`D_width-1:0] MulP3_in,
  input  logic [`D_width-1:0] MulP4_in,
  input  logic [`D_width-1:0] MulP5_in,
  input  logic [`D_width-1:0] MulP6_in,
  input  logic [`D_width-1:0] MulP7_in,
  input  logic [`D_width-1:0] MulP8_in,
  input  logic [`D_width-1:0] MulP9_in,
  input  logic [`D_width-1:0] MulP10_in,
  input  logic [`D_width-1:0] MulP11_in,
  input  logic [`D_width-1:0] MulP12_in,
  input  logic [`D_width-1:0] MulP13_in,
  input  logic [`D_width-1:0] MulP14_in,
  input  logic [`D_width-1:0] MulP15_in,
  output logic [`D_width-1:0] R16_out0,
  output logic [`D_width-1:0] R16_out1,
  output logic [`D_width-1:0] R16_out2,
  output logic [`D_width-1:0] R16_out3,
  output logic [`D_width-1:0] R16_out4,
  output logic [`D_width-1:0] R16_out5,
  output logic [`D_width-1:0] R16_out6,
  output logic [`D_width-1:0] R16_out7,
  output logic [`D_width-1:0] R16_out8,
  output logic [`D_width-1:0] R16_out9,
  output logic [`D_width-1:0] R16_out10,
  output logic [`D_width-1:0] R16_out11,
  output logic [`D_width-1:0] R16_out12,
  output logic [`D_width-1:0] R16_out13,
  output logic [`D_width-1:0] R16_out14,
  output logic [`D_width-1:0] R16_out15,
  output logic                out_valid,
  output logic                out_last,
  output logic [CNT_W-1:0]    grp_cnt
);

  localparam int DW = `D_width;
  localparam logic [CNT_W-1:0] LAST_GRP = CNT_W'(GROUP_NUM - 1);

  logic [15:0][DW-1:0] byp_in;
  logic [15:0][DW-1:0] mul_in;
  logic [15:0][DW-1:0] out_reg;
  logic [15:0][DW-1:0] lane_nxt;

  // Delay line: stage 0 captures the issue, stage MUL_LAT-1 is the tail.
  logic [MUL_LAT-1:0]                v_pipe;
  logic [MUL_LAT-1:0][1:0]           sel_pipe;
  logic [MUL_LAT-1:0][15:0][DW-1:0]  byp_pipe;

  logic                v_d;
  logic [1:0]          sel_d;
  logic [15:0][DW-1:0] byp_d;

  // Index of the next group to be emitted; grp_cnt shows the one presented.
  logic [CNT_W-1:0]    cnt_next;

  assign byp_in[0]  = R16_in0;   assign byp_in[1]  = R16_in1;
  assign byp_in[2]  = R16_in2;   assign byp_in[3]  = R16_in3;
  assign byp_in[4]  = R16_in4;   assign byp_in[5]  = R16_in5;
  assign byp_in[6]  = R16_in6;   assign byp_in[7]  = R16_in7;
  assign byp_in[8]  = R16_in8;   assign byp_in[9]  = R16_in9;
  assign byp_in[10] = R16_in10;  assign byp_in[11] = R16_in11;
  assign byp_in[12] = R16_in12;  assign byp_in[13] = R16_in13;
  assign byp_in[14] = R16_in14;  assign byp_in[15] = R16_in15;

  assign mul_in[0]  = MulP0_in;  assign mul_in[1]  = MulP1_in;
  assign mul_in[2]  = MulP2_in;  assign mul_in[3]  = MulP3_in;
  assign mul_in[4]  = MulP4_in;  assign mul_in[5]  = MulP5_in;
  assign mul_in[6]  = MulP6_in;  assign mul_in[7]  = MulP7_in;
  assign mul_in[8]  = MulP8_in;  assign mul_in[9]  = MulP9_in;
  assign mul_in[10] = MulP10_in; assign mul_in[11] = MulP11_in;
  assign mul_in[12] = MulP12_in; assign mul_in[13] = MulP13_in;
  assign mul_in[14] = MulP14_in; assign mul_in[15] = MulP15_in;

  assign R16_out0  = out_reg[0];  assign R16_out1  = out_reg[1];
  assign R16_out2  = out_reg[2];  assign R16_out3  = out_reg[3];
  assign R16_out4  = out_reg[4];  assign R16_out5  = out_reg[5];
  assign R16_out6  = out_reg[6];  assign R16_out7  = out_reg[7];
  assign R16_out8  = out_reg[8];  assign R16_out9  = out_reg[9];
  assign R16_out10 = out_reg[10]; assign R16_out11 = out_reg[11];
  assign R16_out12 = out_reg[12]; assign R16_out13 = out_reg[13];
  assign R16_out14 = out_reg[14]; assign R16_out15 = out_reg[15];

  assign v_d   = v_pipe[MUL_LAT-1];
  assign sel_d = sel_pipe[MUL_LAT-1];
  assign byp_d = byp_pipe[MUL_LAT-1];

  // Shift valid, route code and bypass lanes so they meet the products.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_pipe   <= '0;
      sel_pipe <= '0;
      byp_pipe <= '0;
    end else begin
      v_pipe[0]   <= in_valid;
      sel_pipe[0] <= Mul_sel;
      byp_pipe[0] <= byp_in;
      for (int s = 1; s < MUL_LAT; s++) begin
        v_pipe[s]   <= v_pipe[s-1];
        sel_pipe[s] <= sel_pipe[s-1];
        byp_pipe[s] <= byp_pipe[s-1];
      end
    end
  end

  // Route each output lane from bypass, product, reordered product or zero.
  always_comb begin
    lane_nxt = '0;
    for (int k = 0; k < 16; k++) begin
      case (sel_d)
        2'd0:    lane_nxt[k] = byp_d[k];
        2'd1:    lane_nxt[k] = mul_in[k];
`ifdef DTFAG_DEMUX_IFFT_REORDER_EN
        2'd2:    lane_nxt[k] = mul_in[4'(16 - k)];
`else
        2'd2:    lane_nxt[k] = mul_in[k];
`endif
        2'd3:    lane_nxt[k] = '0;
        default: lane_nxt[k] = '0;
      endcase
    end
  end

  // Load the output word and group index on a valid tail; hold on bubbles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_reg   <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      grp_cnt   <= '0;
      cnt_next  <= '0;
    end else begin
      out_valid <= v_d;
      if (v_d) begin
        out_reg  <= lane_nxt;
        grp_cnt  <= cnt_next;
        out_last <= (cnt_next == LAST_GRP);
        cnt_next <= (cnt_next == LAST_GRP) ? '0 : cnt_next + 1'b1;
      end else begin
        out_last <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dtfag_mul_demux.sv
// Self-checking bench for dtfag_mul_demux: randomized and directed stimulus
// against a transaction-level reference model (queues of expected words).
`ifndef D_width
`define D_width 16
`endif

module tb_dtfag_mul_demux;

  localparam int LAT   = 3;
  localparam int GNUM  = 4096;
  localparam int CW    = 12;
  localparam int DW    = `D_width;
`ifdef DTFAG_DEMUX_IFFT_REORDER_EN
  localparam bit REORDER = 1'b1;
`else
  localparam bit REORDER = 1'b0;
`endif

  typedef logic [15:0][DW-1:0] lanes_t;
  typedef struct { int due; lanes_t data; int grp; } exp_t;
  typedef struct { int due; lanes_t p; } prod_t;

  logic clk;
  logic rst;
  logic in_valid;
  logic [1:0] mul_sel;
  lanes_t r16_in;
  lanes_t mulp;
  wire [15:0][DW-1:0] r16_out;
  wire out_valid;
  wire out_last;
  wire [CW-1:0] grp_cnt;

  exp_t  eq[$];
  prod_t pq[$];
  lanes_t hold;
  int hold_grp;
  int gexp;
  int cyc;
  int last_seen;
  int n_checks;
  int n_fail;
  bit chk_en;

  dtfag_mul_demux #(.MUL_LAT(LAT), .GROUP_NUM(GNUM), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .Mul_sel(mul_sel),
    .R16_in0(r16_in[0]),   .R16_in1(r16_in[1]),   .R16_in2(r16_in[2]),   .R16_in3(r16_in[3]),
    .R16_in4(r16_in[4]),   .R16_in5(r16_in[5]),   .R16_in6(r16_in[6]),   .R16_in7(r16_in[7]),
    .R16_in8(r16_in[8]),   .R16_in9(r16_in[9]),   .R16_in10(r16_in[10]), .R16_in11(r16_in[11]),
    .R16_in12(r16_in[12]), .R16_in13(r16_in[13]), .R16_in14(r16_in[14]), .R16_in15(r16_in[15]),
    .MulP0_in(mulp[0]),    .MulP1_in(mulp[1]),    .MulP2_in(mulp[2]),    .MulP3_in(mulp[3]),
    .MulP4_in(mulp[4]),    .MulP5_in(mulp[5]),    .MulP6_in(mulp[6]),    .MulP7_in(mulp[7]),
    .MulP8_in(mulp[8]),    .MulP9_in(mulp[9]),    .MulP10_in(mulp[10]),  .MulP11_in(mulp[11]),
    .MulP12_in(mulp[12]),  .MulP13_in(mulp[13]),  .MulP14_in(mulp[14]),  .MulP15_in(mulp[15]),
    .R16_out0(r16_out[0]),   .R16_out1(r16_out[1]),   .R16_out2(r16_out[2]),   .R16_out3(r16_out[3]),
    .R16_out4(r16_out[4]),   .R16_out5(r16_out[5]),   .R16_out6(r16_out[6]),   .R16_out7(r16_out[7]),
    .R16_out8(r16_out[8]),   .R16_out9(r16_out[9]),   .R16_out10(r16_out[10]), .R16_out11(r16_out[11]),
    .R16_out12(r16_out[12]), .R16_out13(r16_out[13]), .R16_out14(r16_out[14]), .R16_out15(r16_out[15]),
    .out_valid(out_valid), .out_last(out_last), .grp_cnt(grp_cnt)
  );

  initial clk = 1'b0;
  // Free-running clock.
  always #5 clk = ~clk;

  // Cycle index: cycle t spans posedge t .. posedge t+1.
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic lanes_t rand_lanes();
    lanes_t r;
    for (int k = 0; k < 16; k++) r[k] = DW'($urandom);
    return r;
  endfunction

  // Reference: what the word must be for a given route code.
  function automatic lanes_t model(input logic [1:0] sel, input lanes_t byp, input lanes_t prod);
    lanes_t r;
    for (int k = 0; k < 16; k++) begin
      if (sel == 2'd0)      r[k] = byp[k];
      else if (sel == 2'd1) r[k] = prod[k];
      else if (sel == 2'd2) r[k] = REORDER ? prod[(16 - k) % 16] : prod[k];
      else                  r[k] = '0;
    end
    return r;
  endfunction

  // Drive one cycle of input; products for this issue appear LAT cycles later.
  task automatic drive(input bit v, input logic [1:0] sel, input lanes_t byp, input lanes_t prod);
    exp_t e;
    prod_t p;
    in_valid = v;
    mul_sel = sel;
    r16_in = byp;
    if (pq.size() > 0 && pq[0].due == cyc) begin
      mulp = pq[0].p;
      void'(pq.pop_front());
    end else begin
      mulp = rand_lanes();
    end
    if (v) begin
      p.due = cyc + LAT;
      p.p = prod;
      pq.push_back(p);
      e.due = cyc + LAT + 1;
      e.data = model(sel, byp, prod);
      e.grp = gexp;
      eq.push_back(e);
      gexp = (gexp + 1) % GNUM;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic bubble(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 2'($urandom), rand_lanes(), rand_lanes());
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    in_valid = 1'b0;
    eq.delete();
    pq.delete();
    gexp = 0;
    hold = '0;
    hold_grp = 0;
    last_seen = 0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
  endtask

  // Compare DUT outputs against the model on every falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      if (eq.size() > 0 && eq[0].due == cyc) begin
        check("out_valid", out_valid, 1'b1);
        check("data", r16_out, eq[0].data);
        check("grp_cnt", grp_cnt, eq[0].grp);
        check("out_last", out_last, eq[0].grp == GNUM - 1);
        hold = eq[0].data;
        hold_grp = eq[0].grp;
        void'(eq.pop_front());
      end else begin
        check("idle_valid", out_valid, 1'b0);
        check("idle_last", out_last, 1'b0);
        check("hold_data", r16_out, hold);
        check("hold_grp", grp_cnt, hold_grp);
      end
      if (out_last) last_seen++;
    end
  end

  initial begin
    lanes_t a;
    lanes_t b;
    cyc = 0; n_checks = 0; n_fail = 0; chk_en = 1'b0;
    rst = 1'b0; in_valid = 1'b0; mul_sel = 2'd0;
    r16_in = '0; mulp = '0; hold = '0; hold_grp = 0; gexp = 0; last_seen = 0;
    #2;
    chk_en = 1'b1;
    do_reset(2);
    check("rst_valid", out_valid, 1'b0);
    check("rst_grp", grp_cnt, 12'd0);
    check("rst_out3", r16_out[3], 16'h0000);

    // Straight product: lane k = 0x100+k, visible at t+4, not at t+3.
    for (int k = 0; k < 16; k++) b[k] = DW'(16'h100 + k);
    drive(1'b1, 2'd1, rand_lanes(), b);
    bubble(2);
    check("lat_early", out_valid, 1'b0);
    bubble(1);
    check("p_valid", out_valid, 1'b1);
    check("p_lane0", r16_out[0], 16'h0100);
    check("p_lane15", r16_out[15], 16'h010f);
    check("p_grp", grp_cnt, 12'd0);

    // Bypass: lane k = 0xA0+k, products ignored.
    for (int k = 0; k < 16; k++) begin
      a[k] = DW'(16'h00A0 + k);
      b[k] = DW'(16'h00FF);
    end
    drive(1'b1, 2'd0, a, b);
    bubble(3);
    check("byp_lane5", r16_out[5], 16'h00A5);
    check("byp_lane15", r16_out[15], 16'h00AF);
    check("byp_grp", grp_cnt, 12'd1);

    // Reorder code with products k.
    for (int k = 0; k < 16; k++) b[k] = DW'(k);
    drive(1'b1, 2'd2, rand_lanes(), b);
    bubble(3);
    check("ro_lane0", r16_out[0], 16'd0);
    check("ro_lane1", r16_out[1], REORDER ? 16'd15 : 16'd1);
    check("ro_lane15", r16_out[15], REORDER ? 16'd1 : 16'd15);

    // Zero code.
    drive(1'b1, 2'd3, rand_lanes(), rand_lanes());
    bubble(3);
    check("zero_lane7", r16_out[7], 16'd0);

    // Alternating valid/bubble with route code cycling 0..3.
    for (int i = 0; i < 40; i++)
      drive(i % 2 == 0, 2'((i / 2) % 4), rand_lanes(), rand_lanes());
    bubble(LAT + 2);

    // Random mix of valids and bubbles.
    for (int i = 0; i < 300; i++)
      drive($urandom_range(0, 9) < 7, 2'($urandom), rand_lanes(), rand_lanes());
    bubble(LAT + 2);

    // Full frame back-to-back plus one group to see the wrap.
    do_reset(2);
    for (int i = 0; i < GNUM + 1; i++)
      drive(1'b1, 2'($urandom), rand_lanes(), rand_lanes());
    bubble(LAT + 2);
    check("last_once", last_seen, 1);
    check("wrap_grp", grp_cnt, 12'd0);

    // Reset mid-flight drops in-flight groups; next group restarts at 0.
    for (int i = 0; i < 3; i++) drive(1'b1, 2'd1, rand_lanes(), rand_lanes());
    bubble(1);
    do_reset(2);
    bubble(8);
    drive(1'b1, 2'd0, rand_lanes(), rand_lanes());
    bubble(3);
    check("post_rst_valid", out_valid, 1'b1);
    check("post_rst_grp", grp_cnt, 12'd0);
    bubble(LAT + 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
